// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, load/store port and memory side.
// slave  : arbiter view (accepts core requests, drives the memory)
// master : environment view (core requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch vs load/store) in front of one
// single-port memory with a fixed read latency. One read in flight at a time.
// Ties go to data unless fetch has lost MAX_STARVE consecutive idle cycles.
// Optional build macro ARB_RR_EN: replaces the starvation guard with
// round-robin tie breaking (port not granted most recently wins).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | free: pick a winner, issue its access this cycle
// S_WAIT | read outstanding: cnt counts down to the data capture edge
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  mem_port_arbiter_if.slave     bus
);
  localparam int  BE_W      = DATA_W / 8;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       cap_if, cap_d;
  logic       data_wins_tie;
  logic       win_d, win_if;

`ifdef ARB_RR_EN
  logic       last_d_q, last_d_d;   // 1 = data was granted most recently
`else
  logic [3:0] starve_q, starve_d;
`endif

  // Tie-break rule for the current idle cycle
  always_comb begin
`ifdef ARB_RR_EN
    data_wins_tie = ~last_d_q;
`else
    data_wins_tie = (starve_q < 4'(MAX_STARVE));
`endif
  end

  // Next state, grants, memory strobe and capture enables
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    cap_if        = 1'b0;
    cap_d         = 1'b0;
    win_d         = 1'b0;
    win_if        = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.busy      = 1'b0;
`ifdef ARB_RR_EN
    last_d_d      = last_d_q;
`else
    starve_d      = starve_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        win_d  = bus.d_req & (~bus.if_req | data_wins_tie);
        win_if = bus.if_req & ~win_d;

        if (win_d) begin
          bus.d_gnt     = 1'b1;
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.d_we;
          bus.mem_addr  = bus.d_addr;
          bus.mem_wdata = bus.d_wdata;
          bus.mem_be    = bus.d_be;
          if (!bus.d_we) begin
            state_d = S_WAIT;
            cnt_d   = 3'(RD_LAT);
            owner_d = OWN_DATA;
          end
        end else if (win_if) begin
          bus.if_gnt    = 1'b1;
          bus.mem_en    = 1'b1;
          bus.mem_addr  = bus.if_addr;
          bus.mem_be    = {BE_W{1'b1}};
          state_d       = S_WAIT;
          cnt_d         = 3'(RD_LAT);
          owner_d       = OWN_FETCH;
        end

`ifdef ARB_RR_EN
        if (win_d)
          last_d_d = 1'b1;
        else if (win_if)
          last_d_d = 1'b0;
`else
        // fetch that is waiting and loses to data ages; anything else clears
        if (!bus.if_req || win_if)
          starve_d = 4'd0;
        else if (win_d && starve_q != 4'd15)
          starve_d = starve_q + 4'd1;
`endif
      end

      S_WAIT: begin
        bus.busy = 1'b1;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_IDLE;
          cap_if  = (owner_q == OWN_FETCH);
          cap_d   = (owner_q == OWN_DATA);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= OWN_FETCH;
`ifdef ARB_RR_EN
      last_d_q <= 1'b0;
`else
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
`ifdef ARB_RR_EN
      last_d_q <= last_d_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  // Read-return registers: one-cycle valid pulse, data held until next capture
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_rvalid <= cap_if;
      bus.d_rvalid  <= cap_d;
      if (cap_if)
        bus.if_rdata <= bus.mem_rdata;
      if (cap_d)
        bus.d_rdata <= bus.mem_rdata;
    end
  end
endmodule
